sdram_mem_tester: RTL and testbench



---
 rtl/sdram_mem_tester.sv | 155 +++++++++++++++
 tb/tb_sdram_mem_tester.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_mem_tester.sv
// sdram_mem_tester: Avalon-MM pattern writer / pipelined read-back checker for board-level SDRAM validation.
module sdram_mem_tester #(
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 23,
    parameter int BASE_ADDR       = 0,
    parameter int NUM_WORDS       = 4194304,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LFSR_SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  stop,
    input  logic [1:0]            mode,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_write,
    output logic                  avm_read,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [31:0]           error_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [15:0]           pass_count
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
    localparam logic [31:0] LAST = 32'(NUM_WORDS - 1);
    localparam logic [15:0] SEED = 16'(LFSR_SEED);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [31:0]       wr_idx, iss_idx, rcv_idx;
    logic [OW-1:0]     outstanding;
    logic [15:0]       wr_lfsr, rd_lfsr;
    logic [1:0]        mode_r;
    logic              stop_r, have_err;
    logic              wr_acc, rd_acc, rv, drain_end;
    logic [DATA_W-1:0] exp_rd;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [31:0] idx,
                                                  input logic [15:0] l, input logic p);
        logic [DATA_W-1:0] rep;
        for (int k = 0; k < DATA_W; k++) rep[k] = l[k % 16];
        return m == 2'd0 ? DATA_W'(idx) :
               m == 2'd1 ? rep :
               m == 2'd2 ? ({(DATA_W/2){2'b01}} ^ {DATA_W{idx[0] ^ p}}) :
                           {DATA_W{~p}};
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] i);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(i * (DATA_W / 8));
    endfunction

    assign avm_write      = state == WRITE;
    assign avm_read       = state == READ && outstanding < MAX_O;
    assign avm_address    = avm_write ? word_addr(wr_idx) : avm_read ? word_addr(iss_idx) : ADDR_W'(BASE_ADDR);
    assign avm_writedata  = avm_write ? pattern(mode_r, wr_idx, wr_lfsr, pass_count[0]) : '0;
    assign avm_byteenable = '1;
    assign wr_acc         = avm_write && !avm_waitrequest;
    assign rd_acc         = avm_read && !avm_waitrequest;
    // Stray readdatavalid (e.g. from reads issued before a reset) is dropped here.
    assign rv             = avm_readdatavalid && (state == READ || state == DRAIN) && outstanding != '0;
    assign drain_end      = state == DRAIN && outstanding == '0;
    assign exp_rd         = pattern(mode_r, rcv_idx, rd_lfsr, pass_count[0]);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WRITE;
            WRITE:   if (wr_acc && wr_idx == LAST) state_next = READ;
            READ:    if (rd_acc && iss_idx == LAST) state_next = DRAIN;
            DRAIN:   if (drain_end) state_next = (continuous && !stop_r && !stop) ? WRITE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_idx         <= '0;
            iss_idx        <= '0;
            rcv_idx        <= '0;
            outstanding    <= '0;
            wr_lfsr        <= SEED;
            rd_lfsr        <= SEED;
            mode_r         <= '0;
            stop_r         <= 1'b0;
            have_err       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            pass_count     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding + OW'(rd_acc) - OW'(rv);
            if (state == IDLE && start) begin
                busy           <= 1'b1;
                done           <= 1'b0;
                pass           <= 1'b0;
                error_count    <= '0;
                first_err_addr <= '0;
                have_err       <= 1'b0;
                pass_count     <= '0;
                mode_r         <= mode;
                stop_r         <= 1'b0;
                wr_idx         <= '0;
                wr_lfsr        <= SEED;
            end
            if (busy && stop) stop_r <= 1'b1;
            if (wr_acc) begin
                wr_idx  <= wr_idx + 1;
                wr_lfsr <= lfsr_next(wr_lfsr);
            end
            if (wr_acc && wr_idx == LAST) begin
                iss_idx <= '0;
                rcv_idx <= '0;
                rd_lfsr <= SEED;
            end
            if (rd_acc) iss_idx <= iss_idx + 1;
            if (rv) begin
                rcv_idx <= rcv_idx + 1;
                rd_lfsr <= lfsr_next(rd_lfsr);
                if (avm_readdata != exp_rd) begin
                    if (error_count != '1) error_count <= error_count + 1;
                    if (!have_err) first_err_addr <= word_addr(rcv_idx);
                    have_err <= 1'b1;
                end
            end
            if (drain_end) begin
                pass_count <= pass_count + 1;
                wr_idx     <= '0;
                wr_lfsr    <= SEED;
            end
            if (state == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= error_count == '0;
            end
        end
    end
endmodule

// File: tb/tb_sdram_mem_tester.sv
// tb_sdram_mem_tester: directed checks of sdram_mem_tester against a small Avalon SDRAM responder.
module tb_sdram_mem_tester;
    logic        clk = 0, reset = 1, start = 0, continuous = 0, stop = 0;
    logic [1:0]  mode = 0;
    logic [22:0] avm_address, first_err_addr;
    logic        avm_write, avm_read, avm_waitrequest = 0, avm_readdatavalid = 0;
    logic [15:0] avm_writedata, avm_readdata = 0, pass_count;
    logic [1:0]  avm_byteenable;
    logic        busy, done, pass;
    logic [31:0] error_count;

    sdram_mem_tester #(.NUM_WORDS(16), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .stop(stop), .mode(mode),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_err_addr(first_err_addr), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, lat = 0, max_if = 0, inflight = 0, stall_bad = 0, wn = 0, rdv_n = 0, ri;
    bit rand_wait = 0, corrupt = 0, prev_stall = 0, prev_w, prev_r;
    logic [22:0] prev_addr;
    logic [15:0] prev_data;
    logic [15:0] mem [16];
    logic [15:0] wlog_data [64];
    logic [22:0] wlog_addr [64];
    int q_idx[$], q_due[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic clear_log();
        wn = 0;
        rdv_n = 0;
        max_if = 0;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Responder: drives waitrequest/readdatavalid at the falling edge, in-order read return after lat+1 cycles.
    always @(negedge clk) begin
        cyc++;
        if (prev_stall && (avm_address != prev_addr || avm_writedata != prev_data ||
                           avm_write != prev_w || avm_read != prev_r)) stall_bad++;
        avm_readdatavalid = 0;
        avm_readdata = '0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            ri = q_idx.pop_front();
            void'(q_due.pop_front());
            avm_readdatavalid = 1;
            avm_readdata = mem[ri] ^ ((corrupt && ri == 5) ? 16'h0008 : 16'h0000);
            rdv_n++;
        end
        inflight = q_due.size() + int'(avm_readdatavalid);
        if (inflight > max_if) max_if = inflight;
        avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        if (avm_write && !avm_waitrequest) begin
            mem[avm_address[4:1]] = avm_writedata;
            if (wn < 64) begin
                wlog_addr[wn] = avm_address;
                wlog_data[wn] = avm_writedata;
            end
            wn++;
        end
        if (avm_read && !avm_waitrequest) begin
            q_idx.push_back(int'(avm_address[4:1]));
            q_due.push_back(cyc + 1 + lat);
        end
        prev_stall = (avm_write || avm_read) && avm_waitrequest;
        prev_w = avm_write;
        prev_r = avm_read;
        prev_addr = avm_address;
        prev_data = avm_writedata;
    end

    initial begin
        int bad, sb, n;
        logic [15:0] l;
        repeat (3) tick();
        reset = 0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_errcnt", error_count, 0);
        check("rst_firsterr", first_err_addr, 0);
        check("rst_passcnt", pass_count, 0);
        check("rst_wr_rd", {avm_write, avm_read}, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("byteenable", avm_byteenable, 2'b11);

        clear_log();
        mode = 0;
        pulse_start();
        check("t1_busy", busy, 1);
        wait_done("t1_done");
        bad = 0;
        for (int i = 0; i < 16; i++) if (wlog_addr[i] != 23'(2 * i) || wlog_data[i] != 16'(i)) bad++;
        check("t1_nwrites", wn, 16);
        check("t1_write_seq", bad, 0);
        check("t1_pass", pass, 1);
        check("t1_errcnt", error_count, 0);
        check("t1_passcnt", pass_count, 1);
        check("t1_busy_end", busy, 0);

        clear_log();
        corrupt = 1;
        pulse_start();
        wait_done("t2_done");
        corrupt = 0;
        check("t2_errcnt", error_count, 1);
        check("t2_firsterr", first_err_addr, 10);
        check("t2_pass", pass, 0);

        clear_log();
        mode = 1;
        rand_wait = 1;
        sb = stall_bad;
        pulse_start();
        wait_done("t3_done");
        rand_wait = 0;
        check("t3_w0", wlog_data[0], 16'hACE1);
        check("t3_w1", wlog_data[1], 16'hE270);
        check("t3_w2", wlog_data[2], 16'h7138);
        check("t3_w3", wlog_data[3], 16'h389C);
        bad = 0;
        l = 16'hACE1;
        for (int i = 0; i < 16; i++) begin
            if (wlog_data[i] != l) bad++;
            l = lfsr_step(l);
        end
        check("t3_lfsr_seq", bad, 0);
        check("t3_stable_stall", stall_bad - sb, 0);
        check("t3_pass", pass, 1);

        clear_log();
        mode = 0;
        lat = 9;
        pulse_start();
        wait_done("t4_done");
        check("t4_max_inflight", max_if, 4);
        check("t4_words_read", rdv_n, 16);
        check("t4_pass", pass, 1);

        clear_log();
        mode = 3;
        lat = 0;
        continuous = 1;
        pulse_start();
        n = 0;
        while (pass_count != 1 && n < 1000) begin
            tick();
            n++;
        end
        check("t5_reach_pass2", pass_count, 1);
        stop = 1;
        tick();
        stop = 0;
        wait_done("t5_done");
        continuous = 0;
        bad = 0;
        for (int i = 0; i < 32; i++) if (wlog_data[i] != (i < 16 ? 16'hFFFF : 16'h0000)) bad++;
        check("t5_nwrites", wn, 32);
        check("t5_data_alt", bad, 0);
        check("t5_passcnt", pass_count, 2);
        check("t5_pass", pass, 1);

        clear_log();
        mode = 0;
        lat = 9;
        pulse_start();
        n = 0;
        while (inflight != 3 && n < 1000) begin
            tick();
            n++;
        end
        check("t6_three_inflight", inflight, 3);
        reset = 1;
        tick();
        reset = 0;
        check("t6_rst_wr_rd", {avm_write, avm_read}, 0);
        check("t6_rst_addr", avm_address, 0);
        check("t6_rst_busy_done", {busy, done, pass}, 0);
        check("t6_rst_passcnt", pass_count, 0);
        n = 0;
        while (q_due.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check("t6_late_errcnt", error_count, 0);
        check("t6_late_state", {busy, done, avm_read}, 0);
        lat = 0;
        pulse_start();
        wait_done("t6_done");
        check("t6_pass", pass, 1);
        check("t6_passcnt", pass_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
